// File: rtl/leitor_banco_registradores.sv
// rtl/leitor_banco_registradores.sv - debug dump engine reading a register bank and streaming addr/data words plus an XOR checksum
module leitor_banco_registradores #(
  parameter int LARGURA_DADO = 16,
  parameter int LARGURA_END  = 3,
  parameter int PRIMEIRO     = 0,
  parameter int ULTIMO       = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iniciar,
  output logic [LARGURA_END-1:0]  endereco_leitura,
  input  logic [LARGURA_DADO-1:0] valor_lido,
  input  logic                    pronto,
  output logic                    valido,
  output logic [LARGURA_DADO-1:0] dado_saida,
  output logic [LARGURA_END-1:0]  endereco_saida,
  output logic                    eh_checksum,
  output logic                    ocupado,
  output logic                    fim
);

  typedef enum logic [1:0] {OCIOSO, LER, ENVIAR, CHECKSUM} estado_t;

  localparam logic [LARGURA_END-1:0] END_PRIMEIRO = PRIMEIRO[LARGURA_END-1:0];
  localparam logic [LARGURA_END-1:0] END_ULTIMO   = ULTIMO[LARGURA_END-1:0];
  localparam logic [LARGURA_END-1:0] END_UM       = {{(LARGURA_END-1){1'b0}}, 1'b1};

  estado_t                 estado, prox_estado;
  logic [LARGURA_END-1:0]  contador, prox_contador;
  logic [LARGURA_DADO-1:0] checksum, prox_checksum;
  logic [LARGURA_END-1:0]  prox_endereco_leitura;
  logic                    prox_valido;
  logic [LARGURA_DADO-1:0] prox_dado_saida;
  logic [LARGURA_END-1:0]  prox_endereco_saida;
  logic                    prox_eh_checksum;
  logic                    prox_ocupado;
  logic                    prox_fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= OCIOSO;
      contador         <= END_PRIMEIRO;
      checksum         <= '0;
      endereco_leitura <= '0;
      valido           <= 1'b0;
      dado_saida       <= '0;
      endereco_saida   <= '0;
      eh_checksum      <= 1'b0;
      ocupado          <= 1'b0;
      fim              <= 1'b0;
    end else begin
      estado           <= prox_estado;
      contador         <= prox_contador;
      checksum         <= prox_checksum;
      endereco_leitura <= prox_endereco_leitura;
      valido           <= prox_valido;
      dado_saida       <= prox_dado_saida;
      endereco_saida   <= prox_endereco_saida;
      eh_checksum      <= prox_eh_checksum;
      ocupado          <= prox_ocupado;
      fim              <= prox_fim;
    end
  end

  always_comb begin
    prox_estado         = estado;
    prox_contador       = contador;
    prox_checksum       = checksum;
    prox_valido         = valido;
    prox_dado_saida     = dado_saida;
    prox_endereco_saida = endereco_saida;
    prox_eh_checksum    = eh_checksum;
    prox_ocupado        = ocupado;
    prox_fim            = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          prox_estado   = LER;
          prox_contador = END_PRIMEIRO;
          prox_checksum = '0;
          prox_ocupado  = 1'b1;
        end
      end
      LER: begin
        prox_dado_saida     = valor_lido;
        prox_endereco_saida = contador;
        prox_valido         = 1'b1;
        prox_checksum       = checksum ^ valor_lido;
        prox_estado         = ENVIAR;
      end
      ENVIAR: begin
        if (pronto) begin
          prox_valido = 1'b0;
          // Compare before incrementing so ULTIMO at the top of the range never wraps
          if (contador == END_ULTIMO) begin
            prox_estado         = CHECKSUM;
            prox_dado_saida     = checksum;
            prox_endereco_saida = '0;
            prox_eh_checksum    = 1'b1;
            prox_valido         = 1'b1;
          end else begin
            prox_contador = contador + END_UM;
            prox_estado   = LER;
          end
        end
      end
      CHECKSUM: begin
        if (pronto) begin
          prox_valido      = 1'b0;
          prox_eh_checksum = 1'b0;
          prox_ocupado     = 1'b0;
          prox_fim         = 1'b1;
          prox_estado      = OCIOSO;
        end
      end
      default: prox_estado = OCIOSO;
    endcase

    // Registered read address follows the counter only while the bank is being walked
    prox_endereco_leitura = (prox_estado == LER || prox_estado == ENVIAR) ? prox_contador : '0;
  end

endmodule

// File: tb/tb_leitor_banco_registradores.sv
// tb/tb_leitor_banco_registradores.sv - directed self-checking bench for leitor_banco_registradores
module tb_leitor_banco_registradores;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar, iniciar_n;
  logic        pronto, pronto_n;
  logic [2:0]  endereco_leitura, endereco_leitura_n;
  logic [15:0] valor_lido, valor_lido_n;
  logic        valido, valido_n;
  logic [15:0] dado_saida, dado_saida_n;
  logic [2:0]  endereco_saida, endereco_saida_n;
  logic        eh_checksum, eh_checksum_n;
  logic        ocupado, ocupado_n;
  logic        fim, fim_n;

  logic        bank_we;
  logic [2:0]  bank_waddr;
  logic [15:0] bank_wdata;
  logic [15:0] bank [8];
  logic [15:0] ref_val [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  // Bank model: synchronous write, combinational read, r0 hardwired to zero
  always_ff @(posedge clock) if (bank_we) bank[bank_waddr] <= bank_wdata;
  assign valor_lido   = (endereco_leitura == 3'd0) ? 16'h0 : bank[endereco_leitura];
  assign valor_lido_n = (endereco_leitura_n == 3'd0) ? 16'h0 : bank[endereco_leitura_n];

  leitor_banco_registradores dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .endereco_leitura(endereco_leitura), .valor_lido(valor_lido), .pronto(pronto),
    .valido(valido), .dado_saida(dado_saida), .endereco_saida(endereco_saida),
    .eh_checksum(eh_checksum), .ocupado(ocupado), .fim(fim)
  );

  leitor_banco_registradores #(.PRIMEIRO(2), .ULTIMO(4)) dut_n (
    .clock(clock), .reset(reset), .iniciar(iniciar_n),
    .endereco_leitura(endereco_leitura_n), .valor_lido(valor_lido_n), .pronto(pronto_n),
    .valido(valido_n), .dado_saida(dado_saida_n), .endereco_saida(endereco_saida_n),
    .eh_checksum(eh_checksum_n), .ocupado(ocupado_n), .fim(fim_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    bank_we = 1'b1; bank_waddr = a; bank_wdata = d;
    step();
    bank_we = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("start_ocupado", ocupado, 1);
  endtask

  task automatic expect_word(input logic [2:0] a, input logic [15:0] d, input logic ck);
    int n = 0;
    do begin
      step();
      n++;
    end while (!valido && n < 40);
    check("wait_valido", valido, 1);
    check("word_addr", endereco_saida, a);
    check("word_data", dado_saida, d);
    check("word_eh_checksum", eh_checksum, ck);
  endtask

  task automatic expect_end();
    step();
    check("end_fim", fim, 1);
    check("end_valido", valido, 0);
    check("end_ocupado", ocupado, 0);
    step();
    check("end_fim_clear", fim, 0);
  endtask

  task automatic dump(input logic [15:0] ck);
    start();
    for (int i = 0; i < 8; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    expect_word(3'd0, ck, 1'b1);
    expect_end();
  endtask

  initial begin
    logic exp_v;
    reset = 1'b1; iniciar = 1'b0; iniciar_n = 1'b0; pronto = 1'b1; pronto_n = 1'b1;
    bank_we = 1'b0; bank_waddr = '0; bank_wdata = '0;
    ref_val = '{16'h0000, 16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'h000F, 16'h00F0, 16'h0F00};
    for (int i = 1; i < 8; i++) write_reg(i[2:0], ref_val[i]);

    check("rst_valido", valido, 0);
    check("rst_dado", dado_saida, 0);
    check("rst_end_saida", endereco_saida, 0);
    check("rst_end_leitura", endereco_leitura, 0);
    check("rst_eh_checksum", eh_checksum, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_fim", fim, 0);
    check("rst_valido_n", valido_n, 0);
    reset = 1'b0;
    step();

    // Basic dump, cycle-exact with pronto high
    start();
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_v = ((k % 2 == 1) && k <= 15) || k == 16;
      check($sformatf("basic_valido_c%0d", k), valido, exp_v);
      if (k <= 15 && (k % 2 == 1)) begin
        check("basic_addr", endereco_saida, (k - 1) / 2);
        check("basic_data", dado_saida, ref_val[(k - 1) / 2]);
      end
      if (k == 16) begin
        check("basic_ck_data", dado_saida, 16'hF000);
        check("basic_ck_flag", eh_checksum, 1);
        check("basic_ck_addr", endereco_saida, 0);
      end
      check($sformatf("basic_fim_c%0d", k), fim, k == 17);
    end
    step();
    check("basic_fim_once", fim, 0);

    // Backpressure on addr 3, with a start request while busy
    start();
    for (int i = 0; i < 3; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_word(3'd3, 16'h4444, 1'b0);
    pronto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valido", valido, 1);
      check("stall_data", dado_saida, 16'h4444);
      check("stall_addr", endereco_saida, 3);
    end
    pronto = 1'b1;
    for (int i = 4; i < 8; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    expect_word(3'd0, 16'hF000, 1'b1);
    expect_end();
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_queued_valido", valido, 0);
      check("no_queued_ocupado", ocupado, 0);
    end
    dump(16'hF000);

    // Asynchronous reset while the addr-4 word is presented
    start();
    for (int i = 0; i < 5; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    reset = 1'b1;
    #1;
    check("arst_valido", valido, 0);
    check("arst_ocupado", ocupado, 0);
    check("arst_end_leitura", endereco_leitura, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_no_fim", fim, 0);
    end

    // Fresh dump with a bank write to r5 on the edge it is sampled
    start();
    for (int i = 0; i < 5; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    step();
    bank_we = 1'b1; bank_waddr = 3'd5; bank_wdata = 16'hABCD;
    expect_word(3'd5, 16'h000F, 1'b0);
    bank_we = 1'b0;
    for (int i = 6; i < 8; i++) expect_word(i[2:0], ref_val[i], 1'b0);
    expect_word(3'd0, 16'hF000, 1'b1);
    expect_end();
    ref_val[5] = 16'hABCD;
    dump(16'hF000 ^ 16'h000F ^ 16'hABCD);

    // Narrowed range instance: addrs 2..4
    bank_we = 1'b1; bank_waddr = 3'd5; bank_wdata = 16'h000F;
    step();
    bank_we = 1'b0;
    iniciar_n = 1'b1;
    step();
    iniciar_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("narrow_valido_c%0d", k), valido_n, (k == 1 || k == 3 || k == 5 || k == 6));
      if (k == 1) check("narrow_w2", {endereco_saida_n, dado_saida_n}, {3'd2, 16'h2222});
      if (k == 3) check("narrow_w3", {endereco_saida_n, dado_saida_n}, {3'd3, 16'h4444});
      if (k == 5) check("narrow_w4", {endereco_saida_n, dado_saida_n}, {3'd4, 16'h8888});
      if (k == 6) check("narrow_ck", {eh_checksum_n, dado_saida_n}, {1'b1, 16'hEEEE});
      check($sformatf("narrow_fim_c%0d", k), fim_n, k == 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
